// File: rtl/pc_unit.sv
// Program counter with trap/redirect/stall priority, misaligned-redirect capture,
// and a circular return-address stack whose outputs come from registered state only.
module pc_unit #(
    parameter int          XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int          RAS_DEPTH    = 4,
    parameter int          IALIGN       = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_ras_push,
    input  logic            i_ras_pop,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_bad_addr,
    output logic [XLEN-1:0] o_ras_top,
    output logic            o_ras_empty,
    output logic            o_ras_full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  r_pc;
    logic             r_misaligned;
    logic [XLEN-1:0]  r_bad_addr;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_top_ptr;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  w_pc_plus;
    logic [XLEN-1:0]  w_pc_next;
    logic             w_tgt_misaligned;
    logic             w_reject;
    logic             w_ras_empty;
    logic             w_ras_full;
    logic             w_ras_en;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_ptr_next;
    logic [CNT_W-1:0] w_count_next;

    assign w_pc_plus   = r_pc + XLEN'(4);
    assign w_ras_empty = (r_count == '0);
    assign w_ras_full  = (r_count == CNT_W'(RAS_DEPTH));

    // 16-bit alignment only forbids odd addresses; 32-bit also forbids bit 1.
    assign w_tgt_misaligned = (IALIGN == 16) ? i_redirect_target[0]
                                             : (i_redirect_target[1] | i_redirect_target[0]);
    assign w_reject = i_redirect_valid && !i_trap && w_tgt_misaligned;

    always_comb begin
        w_pc_next = w_pc_plus;
        if (i_trap) begin
            w_pc_next = i_trap_vec;
        end else if (i_redirect_valid) begin
            w_pc_next = w_tgt_misaligned ? r_pc : i_redirect_target;
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc         <= RESET_VECTOR;
            r_misaligned <= 1'b0;
            r_bad_addr   <= '0;
        end else begin
            r_pc         <= w_pc_next;
            r_misaligned <= w_reject;
            if (w_reject) begin
                r_bad_addr <= i_redirect_target;
            end
        end
    end

    always_comb begin
        w_ras_en     = !i_stall && !i_trap;
        w_do_push    = w_ras_en && i_ras_push;
        w_do_pop     = w_ras_en && i_ras_pop;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_top_ptr;
        w_ptr_next   = r_top_ptr;
        w_count_next = r_count;
        if (w_do_push && (!w_do_pop || w_ras_empty)) begin
            // Pointer wrap on a full stack silently drops the oldest entry.
            w_wr_en    = 1'b1;
            w_wr_idx   = r_top_ptr + PTR_W'(1);
            w_ptr_next = r_top_ptr + PTR_W'(1);
            if (!w_ras_full) begin
                w_count_next = r_count + CNT_W'(1);
            end
        end else if (w_do_push && w_do_pop) begin
            w_wr_en = 1'b1;
        end else if (w_do_pop && !w_ras_empty) begin
            w_ptr_next   = r_top_ptr - PTR_W'(1);
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_top_ptr <= '1;
            r_count   <= '0;
        end else begin
            r_top_ptr <= w_ptr_next;
            r_count   <= w_count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_wr_en) begin
            r_ras[w_wr_idx] <= w_pc_plus;
        end
    end

    assign o_pc         = r_pc;
    assign o_pc_plus    = w_pc_plus;
    assign o_misaligned = r_misaligned;
    assign o_bad_addr   = r_bad_addr;
    assign o_ras_top    = w_ras_empty ? '0 : r_ras[r_top_ptr];
    assign o_ras_empty  = w_ras_empty;
    assign o_ras_full   = w_ras_full;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32: width of every address bus.
REQ-002 Parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, power of two >= 2: return-address-stack entries.
REQ-004 Parameter IALIGN, default 32 (legal 32 or 16): instruction alignment in bits; sequential step is 4 bytes.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold PC this cycle.
REQ-008 redirect_valid  in  1  branch/jump taken; load redirect_target.
REQ-009 redirect_target  in  XLEN  branch/jump destination.
REQ-010 trap  in  1  exception/interrupt taken; load trap_vec.
REQ-011 trap_vec  in  XLEN  trap handler address.
REQ-012 ras_push  in  1  call fetched at current pc; push pc_plus.
REQ-013 ras_pop  in  1  return fetched; pop top entry.
REQ-014 pc  out  XLEN  current program counter (registered).
REQ-015 pc_plus  out  XLEN  pc + 4, combinational, modulo 2^XLEN.
REQ-016 misaligned  out  1  registered one-cycle pulse: rejected misaligned redirect.
REQ-017 bad_addr  out  XLEN  registered copy of last rejected redirect_target.
REQ-018 ras_top  out  XLEN  current top-of-stack entry; 0 when empty.
REQ-019 ras_empty  out  1  stack holds zero entries.
REQ-020 ras_full  out  1  stack holds RAS_DEPTH entries.

Function
REQ-021 pc SHALL update only on rising clock; next-value priority: reset > trap > redirect_valid > stall > pc_plus.
REQ-022 trap=1: pc <= trap_vec next cycle, regardless of stall/redirect_valid; trap_vec low bits not checked.
REQ-023 redirect_valid=1, trap=0: target aligned -> pc <= redirect_target, even if stall=1.
REQ-024 Misaligned target: IALIGN=32 -> bit[1]|bit[0] set; IALIGN=16 -> bit[0] set.
REQ-025 Misaligned redirect, trap=0: pc holds; next cycle misaligned=1 and bad_addr=redirect_target.
REQ-026 misaligned SHALL be 1 for exactly one cycle per rejected redirect; bad_addr holds until next rejection or reset.
REQ-027 stall=1, no trap/redirect: pc holds.
REQ-028 No trap/redirect/stall: pc <= pc_plus; wraps 2^XLEN-4 -> 0 with no flag.
REQ-029 RAS: circular buffer of RAS_DEPTH XLEN-bit entries, top pointer, count 0..RAS_DEPTH.
REQ-030 ras_push/ras_pop SHALL be ignored in any cycle with stall=1 or trap=1.
REQ-031 Push only: pc_plus written above top; count += 1, saturating at RAS_DEPTH.
REQ-032 Push when full: oldest entry overwritten (pointer wraps); count stays RAS_DEPTH.
REQ-033 Pop only, count>0: top pointer moves down, count -= 1; pop when empty: no state change.
REQ-034 Push+pop same cycle: top entry replaced by pc_plus; count and pointer unchanged; when empty, acts as push.
REQ-035 ras_top, ras_empty, ras_full SHALL derive from registered state only (no input-to-output path).

Reset
REQ-036 reset=1 at a rising edge: pc=RESET_VECTOR, count=0, misaligned=0, bad_addr=0 next cycle.
REQ-037 Reset SHALL override trap, redirect, stall, and RAS operations in the same cycle; RAS entry storage need not be cleared.
REQ-038 Reset mid-misaligned-pulse SHALL clear misaligned in the following cycle.

Verification
REQ-039 Reset then 3 free cycles (XLEN=32, RESET_VECTOR=0) -> pc = 0, 4, 8, 12; ras_empty=1, ras_top=0.
REQ-040 pc=0x100, stall=1 with redirect_valid=1, target 0x200 -> pc=0x200; next cycle stall only -> pc stays 0x200.
REQ-041 pc=0x40, redirect to 0x202 (IALIGN=32) -> pc stays 0x40, misaligned=1 one cycle, bad_addr=0x202; IALIGN=16 build -> pc=0x202.
REQ-042 trap=1, trap_vec=0x80, redirect to 0x300, stall=1 same cycle -> pc=0x80, no RAS change.
REQ-043 RAS_DEPTH=4: 5 pushes at pc 0x0,0x4,0x8,0xC,0x10 -> ras_full=1, ras_top=0x14; 4 pops -> ras_empty=1; 5th pop no change.
REQ-044 pc=0xFFFFFFFC free-running -> pc=0x0 next cycle; push+pop same cycle with count=2 -> count 2, ras_top=new pc_plus.
